// File: rtl/nes_vga_pkg.sv
// rtl/nes_vga_pkg.sv - shared frame buffer geometry, pixel/address types and helpers
package nes_vga_pkg;

  localparam int FB_W = 256;
  localparam int FB_H = 240;

  typedef logic [8:0]  rgb_t;
  typedef logic [15:0] fb_addr_t;

  // One queued pixel write: target address plus its colour.
  typedef struct packed {
    fb_addr_t addr;
    rgb_t     data;
  } wr_entry_t;

  // Row-major, 256 entries per row, so the address is just {y, x}.
  function automatic fb_addr_t fb_addr(input logic [7:0] x, input logic [7:0] y);
    return {y, x};
  endfunction

  // Rows 240..255 are outside the visible frame and never touch the RAM.
  function automatic logic y_in_range(input logic [7:0] y);
    return y < 8'(FB_H);
  endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// rtl/fb_wr_fifo.sv - synchronous write queue holding pending frame buffer writes
module fb_wr_fifo
  import nes_vga_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  wr_entry_t                push_data,
  input  logic                     pop,
  output wr_entry_t                pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  wr_entry_t     mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; push on full and pop on empty are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Entry storage needs no reset; only slots behind the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/fb_arbiter.sv
// rtl/fb_arbiter.sv - single RAM port arbiter: scanout reads first, queued PPU writes fill idle cycles
module fb_arbiter
  import nes_vga_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          pix_clk,
  input  logic                          reset,
  input  logic                          rd_req,
  input  logic [7:0]                    rd_x,
  input  logic [7:0]                    rd_y,
  output logic [8:0]                    rd_data,
  output logic                          rd_valid,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [7:0]                    wr_x,
  input  logic [7:0]                    wr_y,
  input  logic [8:0]                    wr_data,
  output logic                          wr_dropped,
  output logic [15:0]                   ram_addr,
  output logic                          ram_we,
  output logic [8:0]                    ram_wdata,
  input  logic [8:0]                    ram_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  wr_entry_t push_entry;
  wr_entry_t head;
  logic      fifo_full;
  logic      fifo_empty;
  logic      wr_accept;
  logic      push;
  logic      pop;
  logic      rd_hit;

  // Read pipeline: valid and "force zero" flags ride alongside the RAM access.
  logic      rd_v1;
  logic      rd_z1;
  logic      rd_v2;
  logic      rd_z2;

  // Ready ignores a same-cycle pop so it depends only on registered state.
  assign wr_ready   = !fifo_full;
  assign wr_accept  = wr_valid && !fifo_full;
  assign push       = wr_accept && y_in_range(wr_y);
  assign push_entry = {fb_addr(wr_x, wr_y), wr_data};

  // An out-of-range read leaves the port free for a write pop.
  assign rd_hit     = rd_req && y_in_range(rd_y);
  assign pop        = !rd_hit && !fifo_empty;

  fb_wr_fifo #(
    .DEPTH     (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk       (pix_clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // RAM port registers: read address wins, otherwise drain one queued write.
  always_ff @(posedge pix_clk) begin
    if (reset) begin
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
    end else if (rd_hit) begin
      ram_addr  <= fb_addr(rd_x, rd_y);
      ram_we    <= 1'b0;
    end else if (pop) begin
      ram_addr  <= head.addr;
      ram_wdata <= head.data;
      ram_we    <= 1'b1;
    end else begin
      ram_we    <= 1'b0;
    end
  end

  // Read return path: two flag stages, then capture RAM data or zero.
  always_ff @(posedge pix_clk) begin
    if (reset) begin
      rd_v1    <= 1'b0;
      rd_z1    <= 1'b0;
      rd_v2    <= 1'b0;
      rd_z2    <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_v1    <= rd_req;
      rd_z1    <= !rd_hit;
      rd_v2    <= rd_v1;
      rd_z2    <= rd_z1;
      rd_valid <= rd_v2;
      rd_data  <= (rd_v2 && !rd_z2) ? ram_rdata : '0;
    end
  end

  // Flag accepted writes that fell outside the visible frame.
  always_ff @(posedge pix_clk) begin
    if (reset) begin
      wr_dropped <= 1'b0;
    end else begin
      wr_dropped <= wr_accept && !y_in_range(wr_y);
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// tb/tb_fb_arbiter.sv - randomized scoreboard bench for fb_arbiter
module tb_fb_arbiter;

  localparam int DEPTH = 4;

  logic        pix_clk;
  logic        reset;
  logic        rd_req;
  logic [7:0]  rd_x;
  logic [7:0]  rd_y;
  logic [8:0]  rd_data;
  logic        rd_valid;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_x;
  logic [7:0]  wr_y;
  logic [8:0]  wr_data;
  logic        wr_dropped;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [8:0]  ram_wdata;
  logic [8:0]  ram_rdata;
  logic [$clog2(DEPTH):0] fifo_level;

  fb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .pix_clk    (pix_clk),
    .reset      (reset),
    .rd_req     (rd_req),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_data    (wr_data),
    .wr_dropped (wr_dropped),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .fifo_level (fifo_level)
  );

  initial begin
    pix_clk = 1'b0;
    forever #5 pix_clk = ~pix_clk;
  end

  // Frame buffer RAM seen by the DUT: synchronous, read-first.
  logic [8:0] ram [0:65535];
  always @(posedge pix_clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  // Reference model state.
  typedef struct { logic [15:0] addr; logic [8:0] data; } pend_t;
  typedef struct { int due; logic [8:0] data; } rd_exp_t;
  typedef struct { int due; logic [15:0] addr; logic [8:0] data; } wr_exp_t;

  logic [8:0] mem_ref [0:65535];
  pend_t      q_ref[$];
  rd_exp_t    rd_q[$];
  wr_exp_t    wr_q[$];

  int  edge_count = 0;
  int  checks = 0;
  int  failures = 0;
  bit  armed = 0;
  int  exp_level = 0;
  bit  exp_ready = 1;
  bit  exp_drop = 0;
  bit  exp_rst = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", nm, edge_count, act, exp);
    end
  endtask

  task automatic set_in(input bit rq, input int rx, input int ry,
                        input bit wv, input int wx, input int wy, input int wd);
    rd_req   = rq;
    rd_x     = 8'(rx);
    rd_y     = 8'(ry);
    wr_valid = wv;
    wr_x     = 8'(wx);
    wr_y     = 8'(wy);
    wr_data  = 9'(wd);
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Apply the current inputs to the model, then clock one edge.
  task automatic step();
    int    e;
    bit    acc;
    bit    nd;
    int    a;
    pend_t p;
    e  = edge_count + 1;
    nd = 0;
    if (reset) begin
      q_ref.delete();
      while (rd_q.size() > 0 && rd_q[rd_q.size()-1].due >= e) void'(rd_q.pop_back());
      while (wr_q.size() > 0 && wr_q[wr_q.size()-1].due >= e) void'(wr_q.pop_back());
    end else begin
      acc = wr_valid && (q_ref.size() < DEPTH);
      if (rd_req && rd_y < 8'd240) begin
        a = int'(rd_y) * 256 + int'(rd_x);
        rd_q.push_back('{e + 2, mem_ref[a]});
      end else begin
        if (rd_req) rd_q.push_back('{e + 2, 9'd0});
        if (q_ref.size() > 0) begin
          p = q_ref.pop_front();
          mem_ref[p.addr] = p.data;
          wr_q.push_back('{e, p.addr, p.data});
        end
      end
      nd = acc && (wr_y >= 8'd240);
      if (acc && wr_y < 8'd240)
        q_ref.push_back('{16'(int'(wr_y) * 256 + int'(wr_x)), wr_data});
    end
    @(posedge pix_clk);
    edge_count = e;
    exp_level  = q_ref.size();
    exp_ready  = (exp_level < DEPTH);
    exp_drop   = nd;
    exp_rst    = reset;
    armed      = 1;
    #1;
  endtask

  // Monitor: compare DUT outputs against the model between edges.
  always @(negedge pix_clk) begin
    rd_exp_t r;
    wr_exp_t w;
    if (armed) begin
      chk("fifo_level", 32'(fifo_level), 32'(exp_level));
      chk("wr_ready", 32'(wr_ready), 32'(exp_ready));
      chk("wr_dropped", 32'(wr_dropped), 32'(exp_drop));
      if (exp_rst) begin
        chk("rst_ram_addr", 32'(ram_addr), 32'h0);
        chk("rst_rd_data", 32'(rd_data), 32'h0);
        chk("rst_ram_wdata", 32'(ram_wdata), 32'h0);
      end
      if (rd_q.size() > 0 && rd_q[0].due == edge_count) begin
        r = rd_q.pop_front();
        chk("rd_valid", 32'(rd_valid), 32'h1);
        chk("rd_data", 32'(rd_data), 32'(r.data));
      end else begin
        chk("rd_valid_idle", 32'(rd_valid), 32'h0);
      end
      if (wr_q.size() > 0 && wr_q[0].due == edge_count) begin
        w = wr_q.pop_front();
        chk("ram_we", 32'(ram_we), 32'h1);
        chk("ram_addr", 32'(ram_addr), 32'(w.addr));
        chk("ram_wdata", 32'(ram_wdata), 32'(w.data));
      end else begin
        chk("ram_we_idle", 32'(ram_we), 32'h0);
      end
    end
  end

  initial begin
    int n;
    int wi;
    for (int i = 0; i < 65536; i++) begin
      ram[i]     = 9'($urandom);
      mem_ref[i] = ram[i];
    end
    reset = 1'b1;
    idle();
    #2;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) step();

    // Single write then read back the same pixel.
    set_in(0, 0, 0, 1, 5, 3, 9'h1A5);
    step();
    idle();
    for (int i = 0; i < 3; i++) step();
    set_in(1, 5, 3, 0, 0, 0, 0);
    step();
    idle();
    for (int i = 0; i < 4; i++) step();

    // Read burst starves five offered writes.
    wi = 0;
    for (int i = 0; i < 14; i++) begin
      set_in(i < 8, $urandom_range(0, 255), $urandom_range(0, 239),
             wi < 5, 10 + wi, 20 + wi, 9'h100 + wi);
      if (wi < 5 && q_ref.size() < DEPTH) wi++;
      step();
    end
    idle();
    for (int i = 0; i < 4; i++) step();

    // Boundary pixels.
    set_in(0, 0, 0, 1, 255, 239, 9'h0F3);
    step();
    idle();
    step();
    step();
    set_in(1, 255, 239, 0, 0, 0, 0);
    step();
    set_in(0, 0, 0, 1, 7, 240, 9'h055);
    step();
    set_in(1, 1, 1, 1, 8, 8, 9'h0AA);
    step();
    set_in(1, 1, 250, 0, 0, 0, 0);
    step();
    idle();
    for (int i = 0; i < 4; i++) step();

    // Reset with three writes queued and two reads in flight.
    for (int i = 0; i < 3; i++) begin
      set_in(1, 30 + i, 40 + i, 1, 60 + i, 70 + i, 9'h1C0 + i);
      step();
    end
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) step();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      n = $urandom_range(0, 9);
      set_in($urandom_range(0, 9) < 6, $urandom_range(0, 255),
             ($urandom_range(0, 9) == 0) ? $urandom_range(240, 255) : $urandom_range(0, 239),
             $urandom_range(0, 1) == 1, $urandom_range(0, 255),
             (n == 0) ? $urandom_range(240, 255) : $urandom_range(0, 239),
             $urandom_range(0, 511));
      reset = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 1'b0;
    idle();
    for (int i = 0; i < 12; i++) step();

    chk("rd_q_drained", 32'(rd_q.size()), 32'h0);
    chk("wr_q_drained", 32'(wr_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
